vector_sweep_capture: RTL
=========================

Name: vector_sweep_capture

Overview:
- Exercises the 4-input / 2-output combinational test stage. It sits upstream of the stage, driving A, B, C and D, and downstream of it, consuming W1 and W2.
- On a start pulse it walks all 16 input vectors in order. After each vector it waits a settle interval, then captures {W2,W1} into a 16-entry result store and updates ones-counters.
- Software or a bench reads results back through a registered read port.

Parameters:
SETTLE_CYCLES, 2, cycles each vector is held before sampling; legal range 1..15.

Ports:
clk  input  1  single clock, rising-edge
rst_n  input  1  asynchronous reset, active-low
start  input  1  one-cycle request to begin a sweep; honoured only in IDLE
W1  input  1  stage output 1
W2  input  1  stage output 2
A  output  1  stimulus bit 3 (vector MSB)
B  output  1  stimulus bit 2
C  output  1  stimulus bit 1
D  output  1  stimulus bit 0 (vector LSB)
busy  output  1  high while a sweep is in progress
done  output  1  sticky; set when a sweep completes, cleared by the next accepted start
rd_addr  input  4  result index to read
rd_data  output  2  {W2,W1} captured for vector rd_addr, 1-cycle latency
ones_w1  output  5  count of vectors with W1=1 (0..16)
ones_w2  output  5  count of vectors with W2=1 (0..16)

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset (rst_n=0, asynchronous, any state): state=IDLE, vector index v=0, settle counter=0.
  - Outputs: A,B,C,D=0; busy=0; done=0; ones_w1=ones_w2=0; rd_data=0.
  - All 16 result entries are cleared to 2'b00.
- Stimulus mapping: {A,B,C,D}=v in SETTLE/SAMPLE; {A,B,C,D}=4'b0000 in IDLE. Outputs are registered, with no combinational path from W to A..D.
- State machine:
  - IDLE: busy=0.
    - On start=1: next state SETTLE, v=0, settle counter=SETTLE_CYCLES, ones_w1/ones_w2 cleared, done cleared, busy set.
  - SETTLE: {A,B,C,D}=v held. Counter decrements each cycle. The state lasts exactly SETTLE_CYCLES cycles, then moves to SAMPLE.
  - SAMPLE: one cycle, {A,B,C,D}=v still held.
    - At the closing edge: mem[v]<={W2,W1}; ones_w1+=W1; ones_w2+=W2.
    - If v==15: go to IDLE, set done, clear busy.
    - Else: v<=v+1, counter reloaded to SETTLE_CYCLES, go to SETTLE.
- Timing:
  - Cycle 0 is the cycle in which start is sampled high in IDLE.
  - Vector k is driven during cycles k*(S+1)+1 .. (k+1)*(S+1), where S=SETTLE_CYCLES.
  - done and busy=0 are first visible in cycle 16*(S+1)+1, which is cycle 49 for S=2.
- start while busy: ignored; no restart and no effect on counters.
- start in the same cycle as done becoming visible (state IDLE): accepted as a new sweep.
- Counters: 5-bit, cannot overflow (maximum 16).
- Index wrap: v never wraps in-sweep; the sweep ends at v=15.
- Read port: rd_data<=mem[rd_addr] every cycle regardless of state.
  - Mid-sweep reads return the new value for captured entries. Entries not yet captured return their old contents (previous sweep, or 00 after reset).
  - A read and a capture of the same index on the same edge returns the pre-capture value.
- Reset mid-sweep: the sweep is abandoned immediately and the full reset state applies. A fresh start is required.

Test Plan:
- Reset then idle: assert rst_n=0 asynchronously between edges → all outputs 0 immediately; A..D=0000, busy=0, done=0.
- Full sweep, S=2, real stage attached: pulse start → busy=1 from cycle 1; done=1 and busy=0 at cycle 49. ones_w1=11, ones_w2=12. rd_addr=0 → rd_data=2'b10 the next cycle; rd_addr=5 → 2'b01; rd_addr=15 → 2'b11.
- Stimulus timing, S=2: check that {A,B,C,D} is 0000 in cycles 1-3, 0001 in cycles 4-6, 1111 in cycles 46-48, and 0000 from cycle 49.
- Start while busy: second start pulse at cycle 10 → no change in v or counters; done still at cycle 49.
- Reset mid-sweep: rst_n low at cycle 20 → counters 0, rd_data of every index reads 00 afterward. A new start then completes normally with 11/12.
- Back-to-back and S=1: start asserted in the done cycle → done clears next cycle, new sweep completes at 16*2+1=33 cycles later. Counters restart from 0 and end at 11/12.

Source files
------------

// File: rtl/vector_sweep_capture.sv
// +----------------------------------------------------------------------------+
// | vector_sweep_capture                                                       |
// | Walks all 16 vectors through a 4-in/2-out stage and captures its outputs. |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module vector_sweep_capture #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       W1,
  input  logic       W2,
  output logic       A,
  output logic       B,
  output logic       C,
  output logic       D,
  output logic       busy,
  output logic       done,
  input  logic [3:0] rd_addr,
  output logic [1:0] rd_data,
  output logic [4:0] ones_w1,
  output logic [4:0] ones_w2
);

  localparam logic [3:0] c_settle = 4'(SETTLE_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_SAMPLE = 2'd2
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [3:0] r_vec;
  logic [3:0] r_cnt;
  logic       r_done;
  logic [4:0] r_ones_w1;
  logic [4:0] r_ones_w2;
  logic [1:0] r_rd_data;
  logic [1:0] r_mem [16];
  logic       w_accept;
  logic       w_capture;
  logic       w_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_capture   = 1'b0;
    w_last      = (r_vec == 4'd15);
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_accept    = 1'b1;
          w_state_nxt = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (r_cnt == 4'd1) begin
          w_state_nxt = S_SAMPLE;
        end
      end
      S_SAMPLE: begin
        w_capture   = 1'b1;
        w_state_nxt = w_last ? S_IDLE : S_SETTLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Vector index, settle timer, counters and the result store share one reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vec     <= 4'd0;
      r_cnt     <= 4'd0;
      r_done    <= 1'b0;
      r_ones_w1 <= 5'd0;
      r_ones_w2 <= 5'd0;
      r_rd_data <= 2'b00;
      for (int i = 0; i < 16; i++) begin
        r_mem[i] <= 2'b00;
      end
    end else begin
      r_rd_data <= r_mem[rd_addr];
      if (w_accept) begin
        r_vec     <= 4'd0;
        r_cnt     <= c_settle;
        r_done    <= 1'b0;
        r_ones_w1 <= 5'd0;
        r_ones_w2 <= 5'd0;
      end else if (r_state == S_SETTLE) begin
        r_cnt <= r_cnt - 4'd1;
      end else if (w_capture) begin
        r_mem[r_vec] <= {W2, W1};
        r_ones_w1    <= r_ones_w1 + {4'd0, W1};
        r_ones_w2    <= r_ones_w2 + {4'd0, W2};
        if (w_last) begin
          r_done <= 1'b1;
        end else begin
          r_vec <= r_vec + 4'd1;
          r_cnt <= c_settle;
        end
      end
    end
  end

  assign {A, B, C, D} = (r_state == S_IDLE) ? 4'b0000 : r_vec;
  assign busy    = (r_state != S_IDLE);
  assign done    = r_done;
  assign rd_data = r_rd_data;
  assign ones_w1 = r_ones_w1;
  assign ones_w2 = r_ones_w2;

endmodule

`default_nettype wire
